// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked, parametrised ALU with iterative multiply and divide.
//
// Sits between the register file and the writeback mux. The sequencer raises
// `start` with an opcode and operands; single-cycle ops complete on the
// accepting edge, MUL/DIV run for WIDTH cycles through a shared shift-add /
// restoring-divide datapath. `done` pulses once per accepted op.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   request, only looked at while not busy
//   A, B       in   operands (dividend/multiplicand, divisor/multiplier)
//   operation  in   5-bit opcode, sampled with start
//   result     out  main result: ALU result, low product word or quotient
//   result_hi  out  high product word or remainder, 0 for other ops
//   CF ZF SF OF out carry, zero, sign, signed-overflow flags
//   busy       out  multi-cycle op in progress
//   done       out  one-cycle completion pulse
//
// WIDTH must be 4 or more.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_SBC = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b00110;
  localparam logic [4:0] OP_XOR = 5'b00111;
  localparam logic [4:0] OP_INC = 5'b01000;
  localparam logic [4:0] OP_DEC = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_TST = 5'b01011;
  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b01101;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           stateQ, stateD;
  logic [CW-1:0]    countQ, countD;
  logic [MSB:0]     hiQ, hiD;
  logic [MSB:0]     loQ, loD;
  logic [MSB:0]     opndQ, opndD;
  logic             isDivQ, isDivD;
  logic [MSB:0]     resultQ, resultD;
  logic [MSB:0]     resultHiQ, resultHiD;
  logic             cfQ, cfD, zfQ, zfD, sfQ, sfD, ofQ, ofD;
  logic             doneQ, doneD;

  logic [WIDTH:0]   tmp;
  logic [WIDTH:0]   cfExt;
  logic             ofS;
  logic             keepRes;
  logic             passA;
  logic [MSB:0]     aluRes;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [MSB:0]     divDiff;
  logic             divFits;
  logic [MSB:0]     stepHi;
  logic [MSB:0]     stepLo;

  // Single-cycle ALU. tmp carries the carry-out in its top bit; shifts and
  // rotates place the bit that falls off the end there. Unlisted opcodes
  // (and MUL/DIV, which the FSM overrides) fall to the default that keeps the
  // old result and derives flags from {CF, A}.
  always_comb begin
    cfExt   = {{WIDTH{1'b0}}, cfQ};
    tmp     = {cfQ, A};
    ofS     = 1'b0;
    keepRes = 1'b0;
    passA   = 1'b0;
    case (operation)
      OP_ADD: begin
        tmp = {1'b0, A} + {1'b0, B};
        ofS = (A[MSB] == B[MSB]) && (tmp[MSB] != A[MSB]);
      end
      OP_ADC: begin
        tmp = {1'b0, A} + {1'b0, B} + cfExt;
        ofS = (A[MSB] == B[MSB]) && (tmp[MSB] != A[MSB]);
      end
      OP_SUB: begin
        tmp = {1'b0, A} - {1'b0, B};
        ofS = (A[MSB] != B[MSB]) && (tmp[MSB] != A[MSB]);
      end
      OP_SBC: begin
        tmp = {1'b0, A} - {1'b0, B} - cfExt;
        ofS = (A[MSB] != B[MSB]) && (tmp[MSB] != A[MSB]);
      end
      OP_CMP: begin
        tmp   = {1'b0, A} - {1'b0, B};
        ofS   = (A[MSB] != B[MSB]) && (tmp[MSB] != A[MSB]);
        passA = 1'b1;
      end
      OP_AND: tmp = {1'b0, A & B};
      OP_OR:  tmp = {1'b0, A | B};
      OP_NOT: tmp = {1'b0, ~A};
      OP_XOR: tmp = {1'b0, A ^ B};
      OP_TST: begin
        tmp   = {1'b0, A & B};
        passA = 1'b1;
      end
      OP_INC: begin
        tmp = {1'b0, A} + ONE;
        ofS = !A[MSB] && tmp[MSB];
      end
      OP_DEC: begin
        tmp = {1'b0, A} - ONE;
        ofS = A[MSB] && !tmp[MSB];
      end
      OP_SHL, OP_SAL: tmp = {A, 1'b0};
      OP_SHR: tmp = {A[0], 1'b0, A[MSB:1]};
      OP_SAR: tmp = {A[0], A[MSB], A[MSB:1]};
      OP_ROL: tmp = {A, A[MSB]};
      OP_ROR: tmp = {A[0], A[0], A[MSB:1]};
      OP_RCL: tmp = {A, cfQ};
      OP_RCR: tmp = {A[0], cfQ, A[MSB:1]};
      default: keepRes = 1'b1;
    endcase
    if (keepRes) begin
      aluRes = resultQ;
    end else if (passA) begin
      aluRes = A;
    end else begin
      aluRes = tmp[MSB:0];
    end
  end

  // One iteration of the shared multi-cycle datapath.
  // MUL: hi accumulates the multiplicand when the multiplier LSB (in lo) is
  // set, then {hi, lo} shifts right; after WIDTH steps {hi, lo} is the product.
  // DIV: {rem, quotient} shifts left, the divisor is subtracted when it fits
  // and the quotient bit shifted into lo records whether it did.
  always_comb begin
    mulSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, opndQ} : '0);
    divShift = {hiQ, loQ[MSB]};
    divFits  = (divShift >= {1'b0, opndQ});
    divDiff  = divShift[MSB:0] - opndQ;
    if (isDivQ) begin
      stepHi = divFits ? divDiff : divShift[MSB:0];
      stepLo = {loQ[MSB-1:0], divFits};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], loQ[MSB:1]};
    end
  end

  // Control FSM. IDLE completes single-cycle ops (and divide-by-zero) on the
  // accepting edge or launches a MUL/DIV; RUN steps the datapath and writes
  // the outputs on the last step. Outputs hold unless an op completes.
  always_comb begin
    stateD    = stateQ;
    countD    = countQ;
    hiD       = hiQ;
    loD       = loQ;
    opndD     = opndQ;
    isDivD    = isDivQ;
    resultD   = resultQ;
    resultHiD = resultHiQ;
    cfD       = cfQ;
    zfD       = zfQ;
    sfD       = sfQ;
    ofD       = ofQ;
    doneD     = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start) begin
          if ((operation == OP_MUL) || ((operation == OP_DIV) && (B != '0))) begin
            stateD = RUN;
            countD = CW'(WIDTH);
            hiD    = '0;
            isDivD = (operation == OP_DIV);
            if (operation == OP_DIV) begin
              loD   = A;
              opndD = B;
            end else begin
              loD   = B;
              opndD = A;
            end
          end else if (operation == OP_DIV) begin
            resultD   = '1;
            resultHiD = A;
            cfD       = 1'b1;
            zfD       = 1'b0;
            sfD       = 1'b1;
            ofD       = 1'b1;
            doneD     = 1'b1;
          end else begin
            resultD   = aluRes;
            resultHiD = '0;
            cfD       = tmp[WIDTH];
            zfD       = (tmp == '0);
            sfD       = tmp[MSB];
            ofD       = ofS;
            doneD     = 1'b1;
          end
        end
      end
      RUN: begin
        hiD    = stepHi;
        loD    = stepLo;
        countD = countQ - CW'(1);
        if (countQ == CW'(1)) begin
          stateD    = IDLE;
          doneD     = 1'b1;
          resultD   = stepLo;
          resultHiD = stepHi;
          sfD       = stepLo[MSB];
          if (isDivQ) begin
            cfD = 1'b0;
            ofD = 1'b0;
            zfD = (stepLo == '0);
          end else begin
            cfD = (stepHi != '0);
            ofD = (stepHi != '0);
            zfD = ({stepHi, stepLo} == '0);
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and output registers; reset wins over everything and abandons any
  // multiply/divide in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      countQ    <= '0;
      hiQ       <= '0;
      loQ       <= '0;
      opndQ     <= '0;
      isDivQ    <= 1'b0;
      resultQ   <= '0;
      resultHiQ <= '0;
      cfQ       <= 1'b0;
      zfQ       <= 1'b0;
      sfQ       <= 1'b0;
      ofQ       <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      countQ    <= countD;
      hiQ       <= hiD;
      loQ       <= loD;
      opndQ     <= opndD;
      isDivQ    <= isDivD;
      resultQ   <= resultD;
      resultHiQ <= resultHiD;
      cfQ       <= cfD;
      zfQ       <= zfD;
      sfQ       <= sfD;
      ofQ       <= ofD;
      doneQ     <= doneD;
    end
  end

  assign result    = resultQ;
  assign result_hi = resultHiQ;
  assign CF        = cfQ;
  assign ZF        = zfQ;
  assign SF        = sfQ;
  assign OF        = ofQ;
  assign busy      = (stateQ == RUN);
  assign done      = doneQ;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
//
// Every accepted op pushes its expected outputs and completion cycle onto a
// per-instance queue; a negedge monitor pops and compares whenever done rises.
// Expected values come from an integer reference model of the opcode map.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, ADC = 5'b00010;
  localparam logic [4:0] CMP = 5'b01010, RCR = 5'b10111;
  localparam logic [4:0] MUL = 5'b01100, DIV = 5'b01101;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        cf, zf, sf, of;
    int          due;
  } exp_t;

  logic        clk, reset;
  logic        start8, cf8, zf8, sf8, of8, busy8, done8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, result8, hi8;
  logic        start16, cf16, zf16, sf16, of16, busy16, done16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, result16, hi16;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb8[$];
  exp_t sb16[$];
  logic        mCf8, mCf16;
  logic [15:0] mRes8, mRes16;
  exp_t e8, e16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .operation(op8),
    .result(result8), .result_hi(hi8), .CF(cf8), .ZF(zf8), .SF(sf8), .OF(of8),
    .busy(busy8), .done(done8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .operation(op16),
    .result(result16), .result_hi(hi16), .CF(cf16), .ZF(zf16), .SF(sf16), .OF(of16),
    .busy(busy16), .done(done16)
  );

  // Free-running clock and cycle counter used to time-stamp completions.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Integer reference model of one op at width w.
  function automatic exp_t model(input int w, input logic [4:0] op, input logic [15:0] aIn,
                                 input logic [15:0] bIn, input logic cfIn, input logic [15:0] prevRes);
    longint a, b, c, mask, m1, msbv, t, r, sa, sb, sr, hi;
    logic   useOf;
    exp_t   e;
    a = longint'(aIn);
    b = longint'(bIn);
    c = cfIn ? 64'sd1 : 64'sd0;
    mask = (64'sd1 <<< w) - 1;
    m1 = (64'sd1 <<< (w + 1)) - 1;
    msbv = 64'sd1 <<< (w - 1);
    sa = ((a & msbv) != 0) ? a - mask - 1 : a;
    sb = ((b & msbv) != 0) ? b - mask - 1 : b;
    t = 0; sr = 0; hi = 0; r = -1; useOf = 1'b0;
    e.due = 0;
    if (op == MUL) begin
      t = a * b;
      r = t & mask;
      hi = t >>> w;
      e.cf = (hi != 0); e.of = (hi != 0); e.zf = (t == 0); e.sf = ((r & msbv) != 0);
    end else if (op == DIV) begin
      if (b == 0) begin
        r = mask; hi = a;
        e.cf = 1'b1; e.of = 1'b1; e.zf = 1'b0; e.sf = 1'b1;
      end else begin
        r = a / b; hi = a % b;
        e.cf = 1'b0; e.of = 1'b0; e.zf = (r == 0); e.sf = ((r & msbv) != 0);
      end
    end else begin
      case (op)
        5'b00000: begin t = a + b; sr = sa + sb; useOf = 1'b1; end
        5'b00001: begin t = (a - b) & m1; sr = sa - sb; useOf = 1'b1; end
        5'b00010: begin t = a + b + c; sr = sa + sb + c; useOf = 1'b1; end
        5'b00011: begin t = (a - b - c) & m1; sr = sa - sb - c; useOf = 1'b1; end
        5'b00100: t = a & b;
        5'b00101: t = a | b;
        5'b00110: t = (~a) & mask;
        5'b00111: t = a ^ b;
        5'b01000: begin t = a + 1; sr = sa + 1; useOf = 1'b1; end
        5'b01001: begin t = (a - 1) & m1; sr = sa - 1; useOf = 1'b1; end
        5'b01010: begin t = (a - b) & m1; sr = sa - sb; useOf = 1'b1; r = a; end
        5'b01011: begin t = a & b; r = a; end
        5'b10000, 5'b10010: t = (a <<< 1) & m1;
        5'b10001: t = (a >>> 1) | ((a & 1) <<< w);
        5'b10011: t = (a >>> 1) | (a & msbv) | ((a & 1) <<< w);
        5'b10100: t = ((a <<< 1) & mask) | (a >>> (w - 1)) | ((a >>> (w - 1)) <<< w);
        5'b10101: t = (a >>> 1) | ((a & 1) <<< (w - 1)) | ((a & 1) <<< w);
        5'b10110: t = ((a <<< 1) & m1) | c;
        5'b10111: t = (a >>> 1) | (c <<< (w - 1)) | ((a & 1) <<< w);
        default: begin t = (c <<< w) | a; r = longint'(prevRes); end
      endcase
      if (r == -1) r = t & mask;
      e.cf = (((t >>> w) & 1) != 0);
      e.zf = (t == 0);
      e.sf = (((t >>> (w - 1)) & 1) != 0);
      e.of = useOf && ((sr > msbv - 1) || (sr < -msbv));
    end
    e.res = r[15:0];
    e.hi = hi[15:0];
    return e;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic [15:0] res,
                             input logic [15:0] hi, input logic cf, input logic zf,
                             input logic sf, input logic of);
    checkEq({tag, "_done_cycle"}, cyc, e.due);
    checkEq({tag, "_result"}, {16'h0, res}, {16'h0, e.res});
    checkEq({tag, "_result_hi"}, {16'h0, hi}, {16'h0, e.hi});
    checkEq({tag, "_flags_CZSO"}, {28'h0, cf, zf, sf, of}, {28'h0, e.cf, e.zf, e.sf, e.of});
  endtask

  // Drives one request for a full cycle; when the op is expected to be
  // accepted its model result and completion cycle go onto the scoreboard.
  task automatic applyStimulus(input int w, input logic [4:0] op, input logic [15:0] a,
                               input logic [15:0] b, input bit expectDone);
    exp_t e;
    logic [15:0] am, bm;
    bit multi;
    am = (w == 8) ? {8'h0, a[7:0]} : a;
    bm = (w == 8) ? {8'h0, b[7:0]} : b;
    if (w == 8) begin
      start8 = 1'b1; op8 = op; a8 = am[7:0]; b8 = bm[7:0];
    end else begin
      start16 = 1'b1; op16 = op; a16 = am; b16 = bm;
    end
    if (expectDone) begin
      multi = (op == MUL) || ((op == DIV) && (bm != 16'h0));
      if (w == 8) e = model(8, op, am, bm, mCf8, mRes8);
      else        e = model(16, op, am, bm, mCf16, mRes16);
      e.due = cyc + 1 + (multi ? w : 0);
      if (w == 8) begin sb8.push_back(e); mCf8 = e.cf; mRes8 = e.res; end
      else        begin sb16.push_back(e); mCf16 = e.cf; mRes16 = e.res; end
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  // Scoreboard monitor: any done must match the oldest outstanding op.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      checks++;
      assert (sb8.size() > 0) else begin
        errors++;
        $error("FAIL w8_unexpected_done: observed done=1 required done=0 at cycle %0d", cyc);
      end
      if (sb8.size() > 0) begin
        e8 = sb8.pop_front();
        checkOutput("w8", e8, {8'h0, result8}, {8'h0, hi8}, cf8, zf8, sf8, of8);
      end
    end
    if (done16 === 1'b1) begin
      checks++;
      assert (sb16.size() > 0) else begin
        errors++;
        $error("FAIL w16_unexpected_done: observed done=1 required done=0 at cycle %0d", cyc);
      end
      if (sb16.size() > 0) begin
        e16 = sb16.pop_front();
        checkOutput("w16", e16, result16, hi16, cf16, zf16, sf16, of16);
      end
    end
  end

  initial begin
    logic [4:0]  rop;
    logic [15:0] ra, rb;
    reset = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    mCf8 = 1'b0; mRes8 = '0; mCf16 = 1'b0; mRes16 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released at cycle %0d", cyc);

    checkEq("reset_w8_result", {24'h0, result8, hi8}, 32'h0);
    checkEq("reset_w8_flags", {26'h0, cf8, zf8, sf8, of8, busy8, done8}, 32'h0);
    checkEq("reset_w16_result", {result16, hi16}, 32'h0);
    checkEq("reset_w16_flags", {26'h0, cf16, zf16, sf16, of16, busy16, done16}, 32'h0);

    // Signed overflow on ADD, borrow on SUB, then ADC consuming it, back to back.
    applyStimulus(8, ADD, 16'h7F, 16'h01, 1'b1);
    applyStimulus(8, SUB, 16'h00, 16'h01, 1'b1);
    applyStimulus(8, ADC, 16'h01, 16'h01, 1'b1);

    // MUL 0xFF*0xFF with a start pulsed mid-run and operands changing.
    applyStimulus(8, MUL, 16'hFF, 16'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkEq("mul_busy_high", {31'h0, busy8}, 32'h1);
      if (i == 3) begin
        start8 = 1'b1; op8 = ADD; a8 = 8'h11; b8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    checkEq("mul_busy_low", {31'h0, busy8}, 32'h0);

    applyStimulus(8, DIV, 16'd200, 16'd7, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(8, DIV, 16'd5, 16'd0, 1'b1);

    // Outputs must hold across idle cycles.
    repeat (2) @(negedge clk);
    checkEq("hold_result", {24'h0, result8}, {16'h0, mRes8});
    checkEq("hold_cf", {31'h0, cf8}, {31'h0, mCf8});

    // Random single-cycle ops, one per cycle.
    for (int i = 0; i < 30; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      if ((rop == MUL) || ((rop == DIV) && (rb != 16'h0))) rop = SUB;
      applyStimulus(8, rop, ra, rb, 1'b1);
    end

    // Random multiply/divide.
    for (int i = 0; i < 4; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? MUL : DIV;
      applyStimulus(8, rop, 16'($urandom_range(0, 255)), 16'($urandom_range(1, 255)), 1'b1);
      repeat (8) @(negedge clk);
    end

    // Reset during cycle 3 of a MUL: everything clears, no done follows.
    applyStimulus(8, MUL, 16'h12, 16'h34, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkEq("abort_result", {16'h0, result8, hi8}, 32'h0);
    checkEq("abort_flags", {26'h0, cf8, zf8, sf8, of8, busy8, done8}, 32'h0);
    reset = 1'b0;
    mCf8 = 1'b0; mRes8 = '0; mCf16 = 1'b0; mRes16 = '0;
    repeat (10) @(negedge clk);
    applyStimulus(8, ADD, 16'd2, 16'd3, 1'b1);

    // WIDTH=16: compare equal, borrow into CF, rotate through carry, MUL/DIV.
    applyStimulus(16, CMP, 16'h1234, 16'h1234, 1'b1);
    applyStimulus(16, SUB, 16'h0000, 16'h0001, 1'b1);
    applyStimulus(16, RCR, 16'h0001, 16'h0000, 1'b1);
    applyStimulus(16, MUL, 16'hFFFF, 16'hFFFF, 1'b1);
    repeat (16) @(negedge clk);
    applyStimulus(16, DIV, 16'd50000, 16'd300, 1'b1);
    repeat (16) @(negedge clk);

    for (int i = 0; i < 50 && (sb8.size() + sb16.size()) > 0; i++) @(negedge clk);
    checkEq("scoreboard_drained", sb8.size() + sb16.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
